// File: rtl/btn_pio_multi.sv
// btn_pio_multi: WIDTH-channel button/switch PIO with two-flop synchronisers,
// per-bit debounce, rise/fall edge capture, maskable level IRQ and an
// Avalon-MM slave port with one-cycle registered read latency.
// Optional build macro BTN_PIO_BITCLR_EN: when defined, writes to the
// edge_capture register clear only the bits set in writedata (W1C); when
// undefined, any write to that address clears every captured bit.
module btn_pio_multi #(
  parameter int               WIDTH      = 4,
  parameter int               DB_W       = 16,
  parameter logic [DB_W-1:0]  DB_RESET   = DB_W'(1000),
  parameter logic [WIDTH-1:0] RISE_RESET = '1,
  parameter logic [WIDTH-1:0] FALL_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
  logic [DB_W-1:0]  cnt_q [WIDTH];
  logic [DB_W-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [DB_W-1:0]  db_period_q, db_period_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_s;
  logic [DB_W-1:0]  period_m1_s;
  logic [WIDTH-1:0] evt_s;
  logic [WIDTH-1:0] clr_s;

  // Next-state logic: synchronisers, debounce, edge capture, registers, read mux
  always_comb begin
    wr_s = chipselect & ~write_n;

    // Periods 0 and 1 both mean "update on the first disagreeing cycle".
    if (db_period_q == {DB_W{1'b0}}) begin
      period_m1_s = {DB_W{1'b0}};
    end else begin
      period_m1_s = db_period_q - DB_W'(1);
    end

    sync1_d    = in_port;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = {DB_W{1'b0}};
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = {DB_W{1'b0}};
      end else if (cnt_q[i] >= period_m1_s) begin
        // >= (not ==) so a period shrunk mid-count still forces an update.
        deb_d[i] = sync2_q[i];
        cnt_d[i] = {DB_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end

    evt_s = (deb_q & ~deb_prev_q & rise_en_q) | (~deb_q & deb_prev_q & fall_en_q);

    clr_s = {WIDTH{1'b0}};
    if (wr_s && (address == 3'd3)) begin
`ifdef BTN_PIO_BITCLR_EN
      clr_s = writedata[WIDTH-1:0];
`else
      clr_s = {WIDTH{1'b1}};
`endif
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    // New events override a same-cycle clear.
    edge_cap_d = (edge_cap_q & ~clr_s) | evt_s;

    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    irq_mask_d  = irq_mask_q;
    db_period_d = db_period_q;
    if (wr_s) begin
      case (address)
        3'd1:    rise_en_d   = writedata[WIDTH-1:0];
        3'd2:    irq_mask_d  = writedata[WIDTH-1:0];
        3'd4:    fall_en_d   = writedata[WIDTH-1:0];
        3'd5:    db_period_d = writedata[DB_W-1:0];
        default: ;
      endcase
    end else begin
      db_period_d = db_period_q;
    end

    readdata_d = 32'h0000_0000;
    case (address)
      3'd0:    readdata_d[WIDTH-1:0] = deb_q;
      3'd1:    readdata_d[WIDTH-1:0] = rise_en_q;
      3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      3'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
      3'd4:    readdata_d[WIDTH-1:0] = fall_en_q;
      3'd5:    readdata_d[DB_W-1:0]  = db_period_q;
      default: readdata_d = 32'h0000_0000;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= {WIDTH{1'b0}};
      sync2_q     <= {WIDTH{1'b0}};
      deb_q       <= {WIDTH{1'b0}};
      deb_prev_q  <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {DB_W{1'b0}};
      end
      rise_en_q   <= RISE_RESET;
      fall_en_q   <= FALL_RESET;
      irq_mask_q  <= {WIDTH{1'b0}};
      edge_cap_q  <= {WIDTH{1'b0}};
      db_period_q <= DB_RESET;
      readdata_q  <= 32'h0000_0000;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      db_period_q <= db_period_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  // Level IRQ straight from registered state, no added delay.
  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_btn_pio_multi.sv
// Self-checking bench for btn_pio_multi: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_btn_pio_multi;

  localparam int W = 4;

  logic          clk;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  btn_pio_multi #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: input seen two samples late; the debounced value adopts
  // that delayed input once it has disagreed for max(period,1) straight cycles.
  logic [W-1:0] m_s1, m_s2, m_db, m_dbp, m_rise, m_fall, m_mask, m_cap;
  int           m_per;
  int           m_run [W];
  logic [31:0]  m_rd;

  always @(posedge clk) begin : model_b
    logic [W-1:0] evt, clr, n_db;
    logic [31:0]  n_rd;
    int           need;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
      m_rise = '1; m_fall = '0; m_mask = '0; m_cap = '0;
      m_per = 1000; m_rd = 32'h0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      need = (m_per < 1) ? 1 : m_per;
      n_rd = 32'h0;
      case (address)
        3'd0: n_rd = 32'(m_db);
        3'd1: n_rd = 32'(m_rise);
        3'd2: n_rd = 32'(m_mask);
        3'd3: n_rd = 32'(m_cap);
        3'd4: n_rd = 32'(m_fall);
        3'd5: n_rd = 32'(m_per);
        default: n_rd = 32'h0;
      endcase
      evt = (m_db & ~m_dbp & m_rise) | (~m_db & m_dbp & m_fall);
      clr = '0;
      if (chipselect && !write_n && address == 3'd3) begin
`ifdef BTN_PIO_BITCLR_EN
        clr = writedata[W-1:0];
`else
        clr = '1;
`endif
      end
      n_db = m_db;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_db[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= need) begin n_db[i] = m_s2[i]; m_run[i] = 0; end
        else m_run[i] = m_run[i] + 1;
      end
      m_cap = (m_cap & ~clr) | evt;
      m_dbp = m_db; m_db = n_db; m_s2 = m_s1; m_s1 = in_port;
      if (chipselect && !write_n) begin
        case (address)
          3'd1: m_rise = writedata[W-1:0];
          3'd2: m_mask = writedata[W-1:0];
          3'd4: m_fall = writedata[W-1:0];
          3'd5: m_per  = int'(writedata[15:0]);
          default: ;
        endcase
      end
      m_rd = n_rd;
    end
  end

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    v = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] exp_tab [8];
    logic [31:0] v;
    exp_tab = '{32'h0, 32'hF, 32'h0, 32'h0, 32'h0, 32'd1000, 32'h0, 32'h0};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      do_read(3'(a), v);
      n_vec++;
      if (v !== exp_tab[a]) begin
        n_err++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, v, exp_tab[a]);
      end
    end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_rise_latency;
    logic [31:0] v;
    do_write(3'd5, 32'd4);
    do_write(3'd2, 32'h1);
    repeat (2) @(negedge clk);
    in_port[0] = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL rise_early irq=%b exp=0", irq); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL rise_on_time irq=%b exp=1", irq); end
    do_read(3'd3, v);
    n_vec++;
    if (v !== 32'h1) begin n_err++; $display("FAIL rise_capture got=%h exp=1", v); end
    do_read(3'd0, v);
    n_vec++;
    if (v !== 32'h1) begin n_err++; $display("FAIL rise_data got=%h exp=1", v); end
  endtask

  task automatic test_glitch;
    logic [31:0] v;
    do_write(3'd2, 32'hF);
    do_write(3'd3, 32'hF);
    in_port[2] = 1'b1;
    repeat (3) @(negedge clk);
    in_port[2] = 1'b0;
    repeat (12) @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq got=%b exp=0", irq); end
    do_read(3'd0, v);
    n_vec++;
    if (v !== 32'h1) begin n_err++; $display("FAIL glitch_data got=%h exp=1", v); end
    do_read(3'd3, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL glitch_capture got=%h exp=0", v); end
  endtask

  task automatic test_fall;
    logic [31:0] v;
    do_write(3'd1, 32'h0);
    do_write(3'd4, 32'h2);
    in_port[1] = 1'b1;
    repeat (12) @(negedge clk);
    do_read(3'd3, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL fall_norise got=%h exp=0", v); end
    in_port[1] = 1'b0;
    repeat (12) @(negedge clk);
    do_read(3'd3, v);
    n_vec++;
    if (v !== 32'h2) begin n_err++; $display("FAIL fall_capture got=%h exp=2", v); end
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL fall_irq got=%b exp=1", irq); end
  endtask

  task automatic test_clear;
    logic [31:0] v;
    logic [31:0] exp_v;
    do_write(3'd4, 32'h0);
    do_write(3'd1, 32'hF);
    in_port = '0;
    repeat (12) @(negedge clk);
    do_write(3'd3, 32'hF);
    in_port = 4'b0101;
    repeat (12) @(negedge clk);
    do_read(3'd3, v);
    n_vec++;
    if (v !== 32'h5) begin n_err++; $display("FAIL clear_setup got=%h exp=5", v); end
    do_write(3'd3, 32'h1);
`ifdef BTN_PIO_BITCLR_EN
    exp_v = 32'h4;
`else
    exp_v = 32'h0;
`endif
    do_read(3'd3, v);
    n_vec++;
    if (v !== exp_v) begin n_err++; $display("FAIL clear_write got=%h exp=%h", v, exp_v); end
  endtask

  task automatic test_set_wins;
    logic [31:0] v;
    in_port = '0;
    repeat (12) @(negedge clk);
    do_write(3'd3, 32'hF);
    do_write(3'd2, 32'h1);
    in_port[0] = 1'b1;
    repeat (6) @(negedge clk);
    address = 3'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL setwins_irq got=%b exp=1", irq); end
    do_read(3'd3, v);
    n_vec++;
    if (v[0] !== 1'b1) begin n_err++; $display("FAIL setwins_bit0 got=%b exp=1", v[0]); end
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL setwins_irq_hold got=%b exp=1", irq); end
  endtask

  task automatic test_random;
    logic exp_irq;
    int   bad = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c > 0) begin
        exp_irq = |(m_cap & m_mask);
        n_vec++;
        if (readdata !== m_rd || irq !== exp_irq) begin
          n_err++;
          if (bad < 10)
            $display("FAIL random cyc=%0d readdata=%h exp=%h irq=%b exp=%b",
                     c, readdata, m_rd, irq, exp_irq);
          bad++;
        end
      end
      reset = (c == 1500) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 7) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
      address    = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if (address == 3'd5) writedata = 32'($urandom_range(0, 6));
    end
    chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = '0;
    test_reset();
    test_rise_latency();
    test_glitch();
    test_fall();
    test_clear();
    test_set_wins();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
